// File: rtl/banked_ram_pkg.sv
// ---------------------------------------------------------------------------
// banked_ram_pkg
// Shared definitions for banked_sync_ram and its ram_bank sub-module.
//   - FSM state encoding (ST_CLEAR, ST_RUN)
//   - helpers that derive bank count, bank depth and byte-lane count
//     from the top-level parameters
// Optional feature macro used by the top: BANKED_RAM_CLEAR_EN
// ---------------------------------------------------------------------------
package banked_ram_pkg;

    typedef logic [0:0] ram_state_t;

    // ST_CLEAR doubles as the "not yet ready" state when the zero-fill
    // sequencer is compiled out.
    localparam ram_state_t ST_CLEAR = 1'b0;
    localparam ram_state_t ST_RUN   = 1'b1;

    function automatic int calc_num_banks(input int bank_bits);
        return 2 ** bank_bits;
    endfunction

    function automatic int calc_bank_depth(input int addr_width, input int bank_bits);
        return 2 ** (addr_width - bank_bits);
    endfunction

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// ---------------------------------------------------------------------------
// ram_bank
// One bank of storage: single port, per-byte write enables, registered read.
// Ports:
//   clk    in   clock
//   rst    in   async active-high reset (clears the read register only)
//   en     in   bank selected this cycle
//   we     in   1 = write, 0 = read
//   be     in   byte-lane write enables
//   addr   in   word index within the bank
//   wdata  in   write data
//   rdata  out  registered read data, holds until the next read of this bank
// ---------------------------------------------------------------------------
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            we,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] be,
    input  logic [$clog2(DEPTH)-1:0]        addr,
    input  logic [DATA_WIDTH-1:0]           wdata,
    output logic [DATA_WIDTH-1:0]           rdata
);

    localparam int LANES = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Storage has no reset; only the clear sequencer in the top zeroes it.
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // The read register is kept separate so it can take the async reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/banked_sync_ram.sv
// ---------------------------------------------------------------------------
// banked_sync_ram
// Multi-bank single-port synchronous RAM with request/response handshake,
// byte-lane writes and a one-cycle registered read.
// Ports:
//   clk, rst             clock, async active-high reset
//   req_valid/req_ready  request handshake (ready is registered)
//   req_we, req_addr     write select, word address (bank = address MSBs)
//   req_wdata, req_be    write data, byte-lane enables
//   rsp_valid/rsp_rdata  read response, one cycle after accept
//   init_done            block initialised, stays high until reset
// Macro BANKED_RAM_CLEAR_EN: when defined, every reset is followed by a
// zero-fill of all banks (one index per cycle, all banks in parallel).
// ---------------------------------------------------------------------------
module banked_sync_ram
    import banked_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_BITS  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_be,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
);

    localparam int NUM_BANKS  = calc_num_banks(BANK_BITS);
    localparam int BANK_DEPTH = calc_bank_depth(ADDR_WIDTH, BANK_BITS);
    localparam int LANES      = byte_lanes(DATA_WIDTH);
    localparam int IDX_W      = ADDR_WIDTH - BANK_BITS;

    ram_state_t state_q;

    logic                  accept;
    logic [BANK_BITS-1:0]  req_bank;
    logic [IDX_W-1:0]      req_index;
    logic [NUM_BANKS-1:0]  bank_sel;
    logic [NUM_BANKS-1:0]  bank_en;
    logic                  bank_we;
    logic [IDX_W-1:0]      bank_addr;
    logic [DATA_WIDTH-1:0] bank_wdata;
    logic [LANES-1:0]      bank_be;
    logic [DATA_WIDTH-1:0] bank_rdata [NUM_BANKS];
    logic [BANK_BITS-1:0]  rsp_bank_q;

`ifdef BANKED_RAM_CLEAR_EN
    logic [IDX_W-1:0]      clr_idx_q;
`endif

    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign accept    = req_valid && req_ready;
    assign req_bank  = req_addr[ADDR_WIDTH-1 -: BANK_BITS];
    assign req_index = req_addr[IDX_W-1:0];

    // Bank port steering: normal traffic enables only the decoded bank;
    // during the clear every bank writes zero at the clear index.
    always_comb begin
        bank_sel           = '0;
        bank_sel[req_bank] = 1'b1;
        bank_en            = accept ? bank_sel : '0;
        bank_we            = req_we;
        bank_addr          = req_index;
        bank_wdata         = req_wdata;
        bank_be            = req_be;
`ifdef BANKED_RAM_CLEAR_EN
        if (state_q == ST_CLEAR) begin
            bank_en    = '1;
            bank_we    = 1'b1;
            bank_addr  = clr_idx_q;
            bank_wdata = '0;
            bank_be    = '1;
        end
`endif
    end

`ifdef BANKED_RAM_CLEAR_EN
    // Clear sequencer: restarts from index 0 on every reset and hands over
    // to RUN on the edge that writes the last index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_idx_q <= clr_idx_q + 1'b1;
            if (clr_idx_q == {IDX_W{1'b1}}) begin
                state_q <= ST_RUN;
            end
        end
    end
`else
    // Without the clear, the block becomes ready on the first edge after
    // reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= ST_RUN;
        end
    end
`endif

    // Response tracking: the bank select is captured with the read so the
    // output mux follows the bank whose register was just loaded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 1'b0;
            rsp_bank_q <= '0;
        end else begin
            rsp_valid <= accept && !req_we;
            if (accept && !req_we) begin
                rsp_bank_q <= req_bank;
            end
        end
    end

    assign rsp_rdata = bank_rdata[rsp_bank_q];

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        ram_bank #(
            .DEPTH      (BANK_DEPTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (bank_en[g]),
            .we    (bank_we),
            .be    (bank_be),
            .addr  (bank_addr),
            .wdata (bank_wdata),
            .rdata (bank_rdata[g])
        );
    end

endmodule

// File: tb/tb_banked_sync_ram.sv
// ---------------------------------------------------------------------------
// tb_banked_sync_ram
// Self-checking bench for banked_sync_ram (ADDR_WIDTH=6, BANK_BITS=2,
// DATA_WIDTH=32, bank depth 16). Expected read data comes from a bench
// memory model and is queued when a read is accepted, then popped when the
// response is due. Honours BANKED_RAM_CLEAR_EN for the ready timing.
// ---------------------------------------------------------------------------
module tb_banked_sync_ram;

`ifdef BANKED_RAM_CLEAR_EN
    localparam bit CLEAR_ON    = 1'b1;
    localparam int READY_DELAY = 16;
`else
    localparam bit CLEAR_ON    = 1'b0;
    localparam int READY_DELAY = 1;
`endif

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] data;
        bit          known;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [5:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_be = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        init_done;

    logic [31:0] model [64];
    bit          known [64];
    exp_t        sb [$];
    logic [31:0] last_exp;
    bit          last_known;
    int          pass_cnt = 0;
    int          total_cnt = 0;

    banked_sync_ram #(
        .ADDR_WIDTH (6),
        .DATA_WIDTH (32),
        .BANK_BITS  (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            $display("[TB] FAIL %s: got %08h expected %08h", tag, obs, exp);
        end else begin
            pass_cnt++;
        end
    endtask

    // One clock: drive at a negedge, let the DUT take the posedge, then
    // check the response produced by that edge at the next negedge.
    task automatic apply_stimulus(input logic v, input logic we, input logic [5:0] addr,
                                  input logic [31:0] wd, input logic [3:0] be);
        logic rd_acc;
        exp_t e;
        req_valid = v;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_be    = be;
        rd_acc    = v && !we && req_ready;
        if (v && we && req_ready) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) model[addr][8*i +: 8] = wd[8*i +: 8];
            end
            if (be == 4'hF) known[addr] = 1'b1;
        end
        if (rd_acc) begin
            e.addr  = addr;
            e.data  = model[addr];
            e.known = known[addr];
            sb.push_back(e);
        end
        @(negedge clk);
        if (rd_acc) begin
            check_output("rsp_valid", {31'b0, rsp_valid}, 32'd1);
            e = sb.pop_front();
            if (e.known) check_output($sformatf("rdata_%02h", e.addr), rsp_rdata, e.data);
            last_exp   = e.data;
            last_known = e.known;
        end else begin
            check_output("rsp_idle", {31'b0, rsp_valid}, 32'd0);
            if (last_known) check_output("rsp_hold", rsp_rdata, last_exp);
        end
    endtask

    task automatic apply_reset(input int hold_cycles);
        rst       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        repeat (hold_cycles) @(negedge clk);
        check_output("rst_ready", {31'b0, req_ready}, 32'd0);
        check_output("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("rst_rdata", rsp_rdata, 32'd0);
        check_output("rst_init_done", {31'b0, init_done}, 32'd0);
        if (CLEAR_ON) begin
            for (int i = 0; i < 64; i++) begin
                model[i] = '0;
                known[i] = 1'b1;
            end
        end
        sb.delete();
        last_exp   = '0;
        last_known = 1'b1;
        rst = 1'b0;
    endtask

    // Hold a read of 0x3F pending and count cycles until the block is ready.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 40) begin
            apply_stimulus(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
            n++;
        end
        check_output({tag, "_cycles"}, n, READY_DELAY);
        check_output({tag, "_init_done"}, {31'b0, init_done}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            model[i] = '0;
            known[i] = 1'b0;
        end
        last_exp   = '0;
        last_known = 1'b1;
        @(negedge clk);

        $display("[TB] reset and initialisation");
        apply_reset(2);
        wait_ready("init");
        apply_stimulus(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);

        $display("[TB] bank isolation");
        apply_stimulus(1'b1, 1'b1, 6'h05, 32'hAAAA5555, 4'hF);
        apply_stimulus(1'b1, 1'b1, 6'h25, 32'h12345678, 4'hF);
        apply_stimulus(1'b1, 1'b0, 6'h05, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 6'h25, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 6'h15, 32'h0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);

        $display("[TB] byte lanes");
        apply_stimulus(1'b1, 1'b1, 6'h10, 32'hFFFFFFFF, 4'hF);
        apply_stimulus(1'b1, 1'b1, 6'h10, 32'h11223344, 4'b0101);
        apply_stimulus(1'b1, 1'b0, 6'h10, 32'h0, 4'h0);
        check_output("byte_lane_model", last_exp, 32'hFF22FF44);
        apply_stimulus(1'b1, 1'b1, 6'h10, 32'h00000000, 4'h0);
        apply_stimulus(1'b1, 1'b0, 6'h10, 32'h0, 4'h0);

        $display("[TB] back-to-back reads");
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 6'(i * 16), 32'(i + 1), 4'hF);
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 6'(i * 16), 32'h0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);

        $display("[TB] read after write");
        apply_stimulus(1'b1, 1'b1, 6'h07, 32'hCAFEF00D, 4'hF);
        apply_stimulus(1'b1, 1'b0, 6'h07, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b1, 6'h37, 32'h0BADBEEF, 4'hF);
        apply_stimulus(1'b1, 1'b0, 6'h37, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 6'h07, 32'h0, 4'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                           6'($urandom_range(0, 63)), $urandom, 4'($urandom_range(0, 15)));
        end
        apply_stimulus(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);

        $display("[TB] reset during clear");
        apply_reset(1);
        repeat (7) apply_stimulus(1'b1, 1'b0, 6'h3F, 32'h0, 4'h0);
        apply_reset(1);
        wait_ready("reclear");
        apply_stimulus(1'b1, 1'b1, 6'h05, 32'h5A5A5A5A, 4'hF);
        apply_stimulus(1'b1, 1'b0, 6'h05, 32'h0, 4'h0);

        $display("[TB] reset after read accept");
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 6'h05;
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 1'b0;
        #1;
        check_output("rst_kill_valid", {31'b0, rsp_valid}, 32'd0);
        check_output("rst_kill_rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        apply_reset(1);
        wait_ready("rerun");
        apply_stimulus(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 6'h05, 32'h0, 4'h0);
        apply_stimulus(1'b1, 1'b0, 6'h25, 32'h0, 4'h0);
        apply_stimulus(1'b0, 1'b0, 6'h00, 32'h0, 4'h0);

        check_output("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
